// File: rtl/parking_space_counter.sv
// ---------------------------------------------------------------------------
// parking_space_counter
//
// Purpose: front end of the parking display path. Synchronises and debounces
// the raw entry/exit car sensors, keeps the number of free spaces as two BCD
// digits, and drives the gate-open outputs, the full flag and the one-cycle
// reject/error pulses.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   car_in         in   raw entry sensor (asynchronous, active-high)
//   car_out        in   raw exit sensor (asynchronous, active-high)
//   free_tens      out  BCD tens digit of free spaces
//   free_ones      out  BCD ones digit of free spaces
//   full           out  high while no space is free
//   gate_in_open   out  entry gate drive
//   gate_out_open  out  exit gate drive
//   reject         out  one-cycle pulse: entry refused, lot full
//   error          out  one-cycle pulse: exit seen while lot already empty
//
// Sensor index 0 is the entry sensor, index 1 is the exit sensor throughout.
// ---------------------------------------------------------------------------
module parking_space_counter #(
    parameter int unsigned CAPACITY         = 20,
    parameter int unsigned DEBOUNCE_CYCLES  = 4,
    parameter int unsigned GATE_HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_in,
    input  logic       car_out,
    output logic [3:0] free_tens,
    output logic [3:0] free_ones,
    output logic       full,
    output logic       gate_in_open,
    output logic       gate_out_open,
    output logic       reject,
    output logic       error
);

    localparam logic [3:0]  CAP_TENS  = 4'(CAPACITY / 10);
    localparam logic [3:0]  CAP_ONES  = 4'(CAPACITY % 10);
    localparam logic        CAP_ZERO  = (CAPACITY == 0);
    localparam logic [7:0]  DB_LIMIT  = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] HOLD_LOAD = 16'(GATE_HOLD_CYCLES - 1);

    typedef enum logic {
        GATE_CLOSED = 1'b0,
        GATE_OPEN   = 1'b1
    } gate_state_e;

    logic [1:0]  raw_s;
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  filt_q;
    logic [1:0]  filt_d;
    logic [1:0]  filt_prev_q;
    logic [1:0]  event_q;
    logic [7:0]  db_cnt_q [2];
    logic [7:0]  db_cnt_d [2];

    logic [3:0]  tens_q;
    logic [3:0]  tens_d;
    logic [3:0]  ones_q;
    logic [3:0]  ones_d;
    logic        full_q;
    logic        full_d;
    logic        reject_q;
    logic        reject_d;
    logic        error_q;
    logic        error_d;
    logic        is_zero_s;
    logic        at_cap_s;
    logic [1:0]  accept_s;

    gate_state_e gate_q  [2];
    logic [15:0] timer_q [2];

    assign raw_s = {car_out, car_in};

    // Debounce next-state: count consecutive samples that disagree with the filtered level
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            filt_d[s]   = filt_q[s];
            db_cnt_d[s] = 8'd0;
            if (sync2_q[s] == filt_q[s]) begin
                db_cnt_d[s] = 8'd0;
            end else if ((db_cnt_q[s] + 8'd1) == DB_LIMIT) begin
                filt_d[s]   = sync2_q[s];
                db_cnt_d[s] = 8'd0;
            end else begin
                db_cnt_d[s] = db_cnt_q[s] + 8'd1;
            end
        end
    end

    // Synchroniser, debounce state and registered rising-edge event detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            filt_q      <= 2'b00;
            filt_prev_q <= 2'b00;
            event_q     <= 2'b00;
            db_cnt_q[0] <= 8'd0;
            db_cnt_q[1] <= 8'd0;
        end else begin
            sync1_q     <= raw_s;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            // Event is registered so the count reacts one cycle after the filtered edge
            event_q     <= filt_q & ~filt_prev_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign is_zero_s = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign at_cap_s  = (tens_q == CAP_TENS) && (ones_q == CAP_ONES);

    // BCD count update, accept decisions and reject/error pulse generation
    always_comb begin
        tens_d   = tens_q;
        ones_d   = ones_q;
        reject_d = 1'b0;
        error_d  = 1'b0;
        accept_s = 2'b00;
        case (event_q)
            2'b01: begin
                if (!is_zero_s) begin
                    accept_s[0] = 1'b1;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end else begin
                    reject_d = 1'b1;
                end
            end
            2'b10: begin
                if (!at_cap_s) begin
                    accept_s[1] = 1'b1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    error_d = 1'b1;
                end
            end
            // Simultaneous entry and exit: the leaving car frees the space, so no reject
            2'b11: begin
                accept_s = 2'b11;
            end
            default: begin
                accept_s = 2'b00;
            end
        endcase
        full_d = (tens_d == 4'd0) && (ones_d == 4'd0);
    end

    // Count digits, full flag and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q   <= CAP_TENS;
            ones_q   <= CAP_ONES;
            full_q   <= CAP_ZERO;
            reject_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            full_q   <= full_d;
            reject_q <= reject_d;
            error_q  <= error_d;
        end
    end

    // Gate FSMs: hold each gate open for GATE_HOLD_CYCLES, re-arming on a new accept
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                gate_q[g]  <= GATE_CLOSED;
                timer_q[g] <= 16'd0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                case (gate_q[g])
                    GATE_CLOSED: begin
                        if (accept_s[g]) begin
                            gate_q[g]  <= GATE_OPEN;
                            timer_q[g] <= HOLD_LOAD;
                        end else begin
                            gate_q[g]  <= GATE_CLOSED;
                            timer_q[g] <= 16'd0;
                        end
                    end
                    GATE_OPEN: begin
                        if (accept_s[g]) begin
                            timer_q[g] <= HOLD_LOAD;
                        end else if (timer_q[g] == 16'd0) begin
                            gate_q[g]  <= GATE_CLOSED;
                        end else begin
                            timer_q[g] <= timer_q[g] - 16'd1;
                        end
                    end
                    default: begin
                        gate_q[g]  <= GATE_CLOSED;
                        timer_q[g] <= 16'd0;
                    end
                endcase
            end
        end
    end

    assign free_tens     = tens_q;
    assign free_ones     = ones_q;
    assign full          = full_q;
    assign reject        = reject_q;
    assign error         = error_q;
    assign gate_in_open  = (gate_q[0] == GATE_OPEN);
    assign gate_out_open = (gate_q[1] == GATE_OPEN);

endmodule

// File: tb/tb_parking_space_counter.sv
// ---------------------------------------------------------------------------
// tb_parking_space_counter
//
// Self-checking bench for parking_space_counter. Two instances share clk and
// rst: dut20 with default parameters and dut3 with CAPACITY=3. A table of
// sensor events with hand-computed expected outputs is replayed, plus hand
// sequences for exact latency/gate duration and reset during an open gate.
// ---------------------------------------------------------------------------
module tb_parking_space_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ci20, co20, ci3, co3;
    logic [3:0] t20, o20, t3, o3;
    logic       f20, gi20, go20, rj20, er20;
    logic       f3, gi3, go3, rj3, er3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parking_space_counter dut20 (
        .clk(clk), .rst(rst), .car_in(ci20), .car_out(co20),
        .free_tens(t20), .free_ones(o20), .full(f20),
        .gate_in_open(gi20), .gate_out_open(go20),
        .reject(rj20), .error(er20)
    );

    parking_space_counter #(.CAPACITY(3)) dut3 (
        .clk(clk), .rst(rst), .car_in(ci3), .car_out(co3),
        .free_tens(t3), .free_ones(o3), .full(f3),
        .gate_in_open(gi3), .gate_out_open(go3),
        .reject(rj3), .error(er3)
    );

    typedef struct {
        int sel;   // 0 = dut20, 1 = dut3
        int ci;
        int co;
        int hold;  // cycles the raw sensor(s) stay high
        int tens;
        int ones;
        int full;
        int gi;
        int go;
        int rej;
        int err;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(int sel, int ci, int co, int hold, int tens, int ones,
                                int full, int gi, int go, int rej, int err);
        row_t r;
        r.sel = sel; r.ci = ci; r.co = co; r.hold = hold;
        r.tens = tens; r.ones = ones; r.full = full;
        r.gi = gi; r.go = go; r.rej = rej; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic get(input int sel, output int t, output int o, output int f,
                       output int gi, output int go, output int rj, output int er);
        if (sel != 0) begin
            t = int'(t3); o = int'(o3); f = int'(f3);
            gi = int'(gi3); go = int'(go3); rj = int'(rj3); er = int'(er3);
        end else begin
            t = int'(t20); o = int'(o20); f = int'(f20);
            gi = int'(gi20); go = int'(go20); rj = int'(rj20); er = int'(er20);
        end
    endtask

    // Edge 0 is the first edge that samples the raw input high; outputs move at edge 7
    task automatic run_row(input int idx, input row_t r);
        int t, o, f, gi, go, rj, er;
        for (int i = 0; i < r.hold + 40; i++) begin
            @(negedge clk);
            if (r.sel != 0) begin
                ci3 = (r.ci != 0) && (i < r.hold);
                co3 = (r.co != 0) && (i < r.hold);
            end else begin
                ci20 = (r.ci != 0) && (i < r.hold);
                co20 = (r.co != 0) && (i < r.hold);
            end
            @(posedge clk);
            #1;
            get(r.sel, t, o, f, gi, go, rj, er);
            if (i == 6) begin
                chk($sformatf("row%0d gate_in before latency", idx), gi, 0);
                chk($sformatf("row%0d gate_out before latency", idx), go, 0);
            end
            if (i == 7) begin
                chk($sformatf("row%0d free_tens", idx), t, r.tens);
                chk($sformatf("row%0d free_ones", idx), o, r.ones);
                chk($sformatf("row%0d full", idx), f, r.full);
                chk($sformatf("row%0d gate_in_open", idx), gi, r.gi);
                chk($sformatf("row%0d gate_out_open", idx), go, r.go);
                chk($sformatf("row%0d reject", idx), rj, r.rej);
                chk($sformatf("row%0d error", idx), er, r.err);
            end
            if (i == 8) begin
                chk($sformatf("row%0d reject one cycle", idx), rj, 0);
                chk($sformatf("row%0d error one cycle", idx), er, 0);
            end
        end
    endtask

    initial begin
        int first_change;
        int gi_cycles;
        int saw_err;
        int saw_go;

        // dut20 rows, starting from 1/9 after the single-entry sequence
        rows.push_back(mk(0, 1, 0, 3,  1, 9, 0, 0, 0, 0, 0)); // glitch ignored
        rows.push_back(mk(0, 0, 1, 10, 2, 0, 0, 0, 1, 0, 0)); // exit back to capacity
        rows.push_back(mk(0, 0, 1, 10, 2, 0, 0, 0, 0, 0, 1)); // exit while empty -> error
        for (int fr = 19; fr >= 9; fr--) begin
            rows.push_back(mk(0, 1, 0, 10, fr / 10, fr % 10, 0, 1, 0, 0, 0));
        end
        rows.push_back(mk(0, 0, 1, 10, 1, 0, 0, 0, 1, 0, 0)); // 0/9 -> 1/0 carry
        // dut3 rows (CAPACITY=3)
        rows.push_back(mk(1, 1, 0, 10, 0, 2, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 10, 0, 1, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 10, 0, 0, 1, 1, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 10, 0, 0, 1, 0, 0, 1, 0)); // full -> reject
        rows.push_back(mk(1, 1, 1, 10, 0, 0, 1, 1, 1, 0, 0)); // simultaneous while full
        rows.push_back(mk(1, 0, 1, 10, 0, 1, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 0, 1, 10, 0, 2, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 0, 1, 10, 0, 3, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 0, 1, 10, 0, 3, 0, 0, 0, 0, 1)); // exit while empty -> error

        // Reset for two cycles
        rst = 1'b1; ci20 = 1'b0; co20 = 1'b0; ci3 = 1'b0; co3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset tens20", int'(t20), 2);
        chk("reset ones20", int'(o20), 0);
        chk("reset full20", int'(f20), 0);
        chk("reset gates20", int'({gi20, go20}), 0);
        chk("reset pulses20", int'({rj20, er20}), 0);
        chk("reset tens3", int'(t3), 0);
        chk("reset ones3", int'(o3), 3);
        chk("reset full3", int'(f3), 0);

        // Single held entry: exact latency, exact gate width, single decrement
        first_change = -1;
        gi_cycles    = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ci20 = (i < 10);
            @(posedge clk);
            #1;
            if (first_change < 0 && (t20 != 4'd2 || o20 != 4'd0)) first_change = i;
            if (gi20) gi_cycles++;
        end
        chk("entry latency edges", first_change, 7);
        chk("entry gate_in width", gi_cycles, 16);
        chk("entry tens", int'(t20), 1);
        chk("entry ones", int'(o20), 9);

        foreach (rows[k]) run_row(k, rows[k]);

        // Reset while the exit gate is open; dut20 starts at 1/0
        saw_err = 0;
        saw_go  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            co20 = (i < 9);
            rst  = (i == 10);
            @(posedge clk);
            #1;
            if (i == 7) begin
                chk("rstseq tens before", int'(t20), 1);
                chk("rstseq ones before", int'(o20), 1);
                chk("rstseq gate open", int'(go20), 1);
            end
            if (i == 9) chk("rstseq gate still open", int'(go20), 1);
            if (i == 10) begin
                chk("rstseq gate dropped", int'(go20), 0);
                chk("rstseq tens reset", int'(t20), 2);
                chk("rstseq ones reset", int'(o20), 0);
                chk("rstseq full reset", int'(f20), 0);
            end
            if (i > 10 && er20) saw_err = 1;
            if (i > 10 && go20) saw_go = 1;
        end
        chk("rstseq no error after reset", saw_err, 0);
        chk("rstseq no gate after reset", saw_go, 0);
        chk("rstseq final tens", int'(t20), 2);
        chk("rstseq final ones", int'(o20), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
